// File: rtl/enemy_wave_grid.sv
// ROWS x COLS enemy formation: marches sideways, drops and reverses at the edges, kill-on-hit.
// Optional WAVE_SPEEDUP_EN shortens the march period as the formation thins out.
module enemy_wave_grid #(
    parameter int          COLS    = 4,
    parameter int          ROWS    = 2,
    parameter int          SPR_W   = 16,
    parameter int          SPR_H   = 16,
    parameter int          GAP_X   = 8,
    parameter int          GAP_Y   = 8,
    parameter int          START_X = 64,
    parameter int          START_Y = 40,
    parameter int          X_MIN   = 0,
    parameter int          X_MAX   = 639,
    parameter int          STEP_X  = 4,
    parameter int          DROP_Y  = 8,
    parameter int          Y_LIMIT = 400,
    parameter logic [7:0]  COLOR   = 8'hE0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    input  logic                 pause,
    input  logic                 game_start_on,
    input  logic                 game_over_on,
    input  logic                 hit_w_enemy,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic [23:0]          wave_speed,
    output logic                 is_active,
    output logic                 e_w_on,
    output logic [7:0]           rgb,
    output logic [ROWS*COLS-1:0] alive_mask,
    output logic                 kill_pulse,
    output logic                 wave_cleared,
    output logic                 reached_bottom
);
    localparam int N       = ROWS * COLS;
    localparam int FW      = COLS * SPR_W + (COLS - 1) * GAP_X;
    localparam int FH      = ROWS * SPR_H + (ROWS - 1) * GAP_Y;
    localparam int PITCH_X = SPR_W + GAP_X;
    localparam int PITCH_Y = SPR_H + GAP_Y;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MARCH   = 2'd1;
    localparam logic [1:0] S_CLEARED = 2'd2;
    localparam logic [1:0] S_LANDED  = 2'd3;

    logic [1:0]   r_state;
    logic [10:0]  r_wave_x;
    logic [10:0]  r_wave_y;
    logic         r_dir_left;
    logic [23:0]  r_cnt;
    logic [N-1:0] r_alive;
    logic         r_kill_pulse;
    logic         r_cleared;

    logic [10:0]     w_px;
    logic [10:0]     w_py;
    logic [COLS-1:0] w_col_hit;
    logic [ROWS-1:0] w_row_hit;
    logic [N-1:0]    w_hit_vec;
    logic [N-1:0]    w_alive_next;
    logic            w_visible;
    logic            w_kill;
    logic            w_clear_now;
    logic [23:0]     w_speed_sel;
    logic [23:0]     w_period;
    logic            w_step;
    logic            w_drop;
    logic [10:0]     w_y_drop;
    logic            w_land;

    assign w_px = {1'b0, x};
    assign w_py = {1'b0, y};

    // Sprite decode: a pixel is inside column c / row r only over the sprite body, never the gap.
    always_comb begin
        w_col_hit = '0;
        w_row_hit = '0;
        w_hit_vec = '0;
        for (int c = 0; c < COLS; c++) begin
            w_col_hit[c] = (w_px >= r_wave_x + 11'(c * PITCH_X)) &&
                           (w_px <  r_wave_x + 11'(c * PITCH_X + SPR_W));
        end
        for (int r = 0; r < ROWS; r++) begin
            w_row_hit[r] = (w_py >= r_wave_y + 11'(r * PITCH_Y)) &&
                           (w_py <  r_wave_y + 11'(r * PITCH_Y + SPR_H));
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_hit_vec[r*COLS+c] = w_row_hit[r] & w_col_hit[c] & r_alive[r*COLS+c];
            end
        end
    end

    assign w_visible    = (r_state == S_MARCH) || (r_state == S_LANDED);
    assign e_w_on       = w_visible && (|w_hit_vec);
    assign rgb          = e_w_on ? COLOR : 8'h00;
    assign w_kill       = (r_state == S_MARCH) && !pause && pix_en && hit_w_enemy && e_w_on;
    assign w_alive_next = r_alive & ~w_hit_vec;
    assign w_clear_now  = w_kill && (w_alive_next == '0);

`ifdef WAVE_SPEEDUP_EN
    int w_alive_cnt;
    always_comb begin
        w_alive_cnt = 0;
        for (int i = 0; i < N; i++) begin
            w_alive_cnt = w_alive_cnt + int'(r_alive[i]);
        end
        if (w_alive_cnt == 1)
            w_speed_sel = wave_speed >> 2;
        else if (w_alive_cnt <= N / 2)
            w_speed_sel = wave_speed >> 1;
        else
            w_speed_sel = wave_speed;
    end
`else
    assign w_speed_sel = wave_speed;
`endif

    assign w_period = (w_speed_sel == 24'd0) ? 24'd1 : w_speed_sel;
    assign w_step   = r_cnt >= (w_period - 24'd1);

    // Edge tests use the whole formation footprint, independent of which columns survive.
    assign w_drop   = r_dir_left ? (r_wave_x < 11'(X_MIN + STEP_X))
                                 : ((r_wave_x + 11'(STEP_X + FW - 1)) > 11'(X_MAX));
    assign w_y_drop = r_wave_y + 11'(DROP_Y);
    assign w_land   = (w_y_drop + 11'(FH - 1)) >= 11'(Y_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wave_x     <= 11'(START_X);
            r_wave_y     <= 11'(START_Y);
            r_dir_left   <= 1'b0;
            r_cnt        <= 24'd0;
            r_alive      <= '0;
            r_kill_pulse <= 1'b0;
            r_cleared    <= 1'b0;
        end else begin
            r_kill_pulse <= 1'b0;
            r_cleared    <= 1'b0;
            if (game_start_on) begin
                r_state    <= S_MARCH;
                r_wave_x   <= 11'(START_X);
                r_wave_y   <= 11'(START_Y);
                r_dir_left <= 1'b0;
                r_cnt      <= 24'd0;
                r_alive    <= '1;
            end else if (game_over_on) begin
                r_state <= S_IDLE;
            end else if ((r_state == S_MARCH) && !pause) begin
                if (w_kill) begin
                    r_alive      <= w_alive_next;
                    r_kill_pulse <= 1'b1;
                    if (w_clear_now) begin
                        r_cleared <= 1'b1;
                        r_state   <= S_CLEARED;
                    end
                end
                if (w_step) begin
                    r_cnt <= 24'd0;
                    if (w_drop) begin
                        r_wave_y   <= w_y_drop;
                        r_dir_left <= ~r_dir_left;
                        if (w_land && !w_clear_now)
                            r_state <= S_LANDED;
                    end else if (r_dir_left) begin
                        r_wave_x <= r_wave_x - 11'(STEP_X);
                    end else begin
                        r_wave_x <= r_wave_x + 11'(STEP_X);
                    end
                end else begin
                    r_cnt <= r_cnt + 24'd1;
                end
            end
        end
    end

    assign is_active      = (r_state == S_MARCH);
    assign reached_bottom = (r_state == S_LANDED);
    assign alive_mask     = r_alive;
    assign kill_pulse     = r_kill_pulse;
    assign wave_cleared   = r_cleared;

endmodule

// File: doc/enemy_wave_grid.md
Name: enemy_wave_grid

Overview:
Parametrised successor to the single enemy wave: a ROWS x COLS formation of enemies marching sideways, dropping and reversing at screen edges, with per-enemy alive bits and kill-on-hit. Sits beside the player and bullet blocks on the pixel scan. Outputs a pixel-on flag and colour for the VGA mixer, plus status for game control.

Parameters:
COLS, 4, enemies per row
ROWS, 2, rows of enemies
SPR_W / SPR_H, 16 / 16, sprite size in pixels
GAP_X / GAP_Y, 8 / 8, spacing between sprites
START_X / START_Y, 64 / 40, formation top-left at load
X_MIN / X_MAX, 0 / 639, horizontal bounds, inclusive
STEP_X, 4, pixels per march step
DROP_Y, 8, pixels per drop
Y_LIMIT, 400, landing line
COLOR, 8'hE0, enemy rgb

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
pix_en  in  1  pixel-clock strobe, qualifies hit sampling
pause  in  1  freeze movement and hits
game_start_on  in  1  load and arm the wave
game_over_on  in  1  stop the wave
hit_w_enemy  in  1  bullet overlaps the current pixel
x, y  in  10 each  current scan coordinate
wave_speed  in  24  clk cycles per march step
is_active  out  1  high in MARCH
e_w_on  out  1  live enemy at (x,y)
rgb  out  8  COLOR when e_w_on, else 0
alive_mask  out  ROWS*COLS  bit r*COLS+c = enemy alive
kill_pulse  out  1  one-cycle pulse per kill
wave_cleared  out  1  one-cycle pulse on last kill
reached_bottom  out  1  held high in LANDED

Behaviour:
- Derived: FW = COLS*SPR_W+(COLS-1)*GAP_X (88); FH = ROWS*SPR_H+(ROWS-1)*GAP_Y (40).
- Reset: state IDLE, wave_x=START_X, wave_y=START_Y, dir=right, speed counter 0, alive_mask 0, all pulse/status outputs 0.
- States: IDLE, MARCH, CLEARED, LANDED. Priority per cycle: rst > game_start_on > game_over_on > hit > step.
- game_start_on high (any state): reload positions, alive all ones, dir right, counter 0; state MARCH from the first cycle it is low.
- game_over_on: to IDLE; position and alive_mask frozen.
- e_w_on/rgb combinational from x, y, registers: high only in MARCH/LANDED, when (x,y) lies inside sprite (r,c) of an alive enemy; gap pixels are 0.
- Kill: in MARCH, !pause, pix_en=1, hit_w_enemy=1, e_w_on=1 -> clear the bit of the enemy under (x,y) next edge, kill_pulse for one cycle. Otherwise hit ignored.
- Speed counter counts in MARCH when !pause; at count >= period-1 reset to 0 and step. period = wave_speed; 0 treated as 1.
- Step: right: if wave_x+STEP_X+FW-1 > X_MAX then wave_y += DROP_Y, dir flips, x unchanged; else wave_x += STEP_X. Left mirrors: wave_x < X_MIN+STEP_X -> drop and flip. Comparisons unsigned, 11 bits, no wrap. Bounds use full formation, not only alive columns.
- After drop, if wave_y+FH-1 >= Y_LIMIT -> LANDED, reached_bottom=1 until start/reset; no further motion.
- alive_mask becoming 0 in MARCH -> CLEARED, wave_cleared one cycle; is_active 0. Kill and step same cycle: both applied, decode uses pre-step position.
- pause: counter, position and alive_mask held; pulses not generated.
- Reset mid-operation returns everything to reset values immediately.

Optional Feature:
WAVE_SPEEDUP_EN: when defined, period = wave_speed>>1 when alive count <= N/2, wave_speed>>2 when alive count == 1 (minimum 1). When undefined, period = wave_speed always.

Test Plan:
- rst, start pulse, wave_speed=3 -> MARCH, wave_x 64->68 after 3 clk, 72 after 6; is_active=1, alive_mask=8'hFF.
- Run to right edge -> wave_x stops at 552; next step wave_y 40->48, dir left, wave_x 552 then 548.
- pix_en, hit at (64,40) -> alive_mask=8'hFE, kill_pulse 1 cycle; hit at (80,40) gap -> no change; hit at (88,64) -> bit 5 cleared.
- pause mid-march for 100 clk -> wave_x, counter, alive_mask unchanged; hits ignored; resumes on release.
- Kill all 8 -> wave_cleared one cycle, state CLEARED, e_w_on 0 everywhere; Y_LIMIT=60 build: first drop to 48 -> 87>=60 -> LANDED, reached_bottom=1, motion stops.
- WAVE_SPEEDUP_EN, wave_speed=8: after 4 kills step every 4 clk; 7 kills every 2 clk; undefined build stays 8.
